output_stream_reader: RTL and testbench
=======================================

# output_stream_reader

Drains a finished result frame out of the accelerator's output memory and presents it as a valid/ready word stream to the host-side interface. A `start` pulse begins the transfer; the block generates read addresses into the output RAM's synchronous read port and absorbs the RAM's one-cycle read latency in a 2-entry FIFO. Downstream backpressure is fully honoured without dropping or duplicating words. It sits directly downstream of the output memory and drives its read port.

## Interface
- `ADD_SIZE`, default 11: output RAM address width.
- `DATA_SIZE`, default 32: word width.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a frame transfer. Sampled only in IDLE.
- `base_address`, in, ADD_SIZE: first word address. Sampled with `start`.
- `frame_len`, in, ADD_SIZE+1: number of words to transfer, 0..2^ADD_SIZE. Sampled with `start`.
- `read_en`, out, 1: RAM read enable.
- `read_address`, out, ADD_SIZE: RAM read address.
- `read_data_out`, in, DATA_SIZE: RAM read data, valid the cycle after `read_en`.
- `m_valid`, out, 1: output word valid.
- `m_ready`, in, 1: downstream accepts.
- `m_data`, out, DATA_SIZE: output word.
- `m_last`, out, 1: final word of the frame, qualified by `m_valid`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at frame completion.

## Operation
- **States: IDLE, READ, FLUSH, DONE.**
- **IDLE**
  - `start`=1 with `frame_len`>0: latch `base_address` and `frame_len`, clear `issued` and `sent`, go to READ.
  - `start`=1 with `frame_len`=0: go to DONE. No beats and no reads occur.
- **READ**
  - `read_en` = (`issued` < len) && (fifo_count + inflight − pop < 2).
    - pop = `m_valid` && `m_ready`.
    - inflight = `read_en` registered one cycle.
  - `read_address` = `base_address` + `issued`, modulo 2^ADD_SIZE (wraps 2^ADD_SIZE−1 → 0).
  - `issued` increments on each `read_en`.
  - When `issued` reaches len, go to FLUSH.
- **Capture:** in the cycle after a `read_en`, `read_data_out` is written into the FIFO. The credit rule guarantees the FIFO never overflows.
- **FLUSH:** no reads. When the beat with `sent` = len−1 is accepted, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Output stream**
  - `m_valid` = FIFO not empty. `m_data` = FIFO head.
  - `m_last` = `m_valid` && (`sent` == len−1).
  - `sent` increments on each handshake.
- **Stream rule:** while `m_valid` && !`m_ready`, `m_data` and `m_last` hold stable and `m_valid` stays high.
- **Ignored inputs:** `start` while `busy` is ignored; the latched parameters are unaffected.
- **Reset**
  - `rst` asserted at any time, including mid-frame, immediately forces IDLE and empties the FIFO.
  - Clears `issued`, `sent`, and inflight.
  - All outputs go to 0: `read_en`, `read_address`, `m_valid`, `m_data`, `m_last`, `busy`, `done`.
  - No `done` pulse is generated for an aborted frame.
- **Widths:** `issued` and `sent` are ADD_SIZE+1 bits, so len = 2^ADD_SIZE (2048 at default) is legal. Address arithmetic is truncated to ADD_SIZE bits.

## Timing
- **Start and first beat**
  - `start` sampled at edge 0.
  - First `read_en` in cycle 1.
  - RAM data arrives in cycle 2 and is written into the FIFO at the end of cycle 2.
  - First `m_valid` in cycle 3.
- **Throughput:** with `m_ready` held high, 1 word/cycle sustained. Beats occur in cycles 3..len+2, `m_last` in cycle len+2, `done` in cycle len+3.
- **Total latency:** `start` to `done` = len+3 cycles with no backpressure. Each cycle of `m_ready`=0 while `m_valid`=1 adds exactly one cycle.
- **Backpressure:** `read_en` deasserts within the same cycle the credit is exhausted. At most 2 words are ever outstanding (FIFO + inflight).
- **`busy` window:** `busy` rises the cycle after accepted `start` and falls the cycle after `done`.
- **Back-to-back frames:** a new `start` is accepted no earlier than the cycle after `done`.

## Test plan
- **Basic frame:** RAM preloaded with addr*3. `start`, base=0, len=8, `m_ready`=1 → `m_data` 0,3,…,21 in cycles 3..10; `m_last` only on 21; `done` in cycle 11; `busy` high cycles 1..11.
- **Backpressure:** len=16, `m_ready` toggling 1,0,0,1 pseudo-randomly → all 16 words delivered in order with no duplicates; `m_data` stable during stalls; `read_en` never leaves more than 2 words outstanding.
- **Address wrap:** base=2046, len=4 → `read_address` sequence 2046, 2047, 0, 1; data matches those locations.
- **Zero length and full length:**
  - len=0 → no `read_en`, no `m_valid`, `done` one cycle after `start`.
  - len=2048 → exactly 2048 beats; `m_last` on beat 2047.
- **Reset mid-frame:** assert `rst` after 5 of 10 beats → all outputs 0 immediately, no `done`. A following `start` with len=3 delivers 3 correct words.
- **Start while busy:** pulse `start` with different base/len during a frame → ignored; the current frame completes unchanged.

Source files
------------

// File: rtl/output_stream_reader_if.sv
// Bundle for the frame reader: start/parameters, output-RAM read port, word stream and status.
// master is the reader; slave is whoever drives start, the RAM data and m_ready.
interface output_stream_reader_if #(
  parameter int ADD_SIZE  = 11,
  parameter int DATA_SIZE = 32
);
  logic                 start;
  logic [ADD_SIZE-1:0]  base_address;
  logic [ADD_SIZE:0]    frame_len;
  logic                 read_en;
  logic [ADD_SIZE-1:0]  read_address;
  logic [DATA_SIZE-1:0] read_data_out;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_last;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, base_address, frame_len, read_data_out, m_ready,
    output read_en, read_address, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, base_address, frame_len, read_data_out, m_ready,
    input  read_en, read_address, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/output_stream_reader.sv
// Streams len words from the output RAM as a valid/ready stream; first beat 3 cycles after start.
// A 2-entry FIFO absorbs the RAM read latency; reads stall when FIFO + inflight would exceed 2.
module output_stream_reader #(
  parameter int ADD_SIZE  = 11,
  parameter int DATA_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output_stream_reader_if.master  bus
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  localparam logic [ADD_SIZE:0] ONE = {{ADD_SIZE{1'b0}}, 1'b1};

  state_t               state;
  logic [ADD_SIZE-1:0]  base;
  logic [ADD_SIZE:0]    len;
  logic [ADD_SIZE:0]    issued;
  logic [ADD_SIZE:0]    sent;
  logic                 inflight;
  logic                 busy_r;
  logic                 done_r;

  logic [DATA_SIZE-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  logic                 valid;
  logic                 pop;
  logic                 rd_go;
  logic [2:0]           credit_used;

  assign valid       = (count != 2'd0);
  assign pop         = valid && bus.m_ready;
  // pop implies count >= 1, so this never underflows
  assign credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_go       = (state == READ) && (issued < len) && (credit_used < 3'd2);

  assign bus.read_en      = rd_go;
  assign bus.read_address = (state == READ) ? base + issued[ADD_SIZE-1:0] : '0;
  assign bus.m_valid      = valid;
  assign bus.m_data       = valid ? mem[rd_ptr] : '0;
  assign bus.m_last       = valid && (sent == len - ONE);
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      len      <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      inflight <= rd_go;
      done_r   <= 1'b0;
      if (rd_go) issued <= issued + ONE;
      if (pop)   sent   <= sent + ONE;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            if (bus.frame_len != '0) begin
              base   <= bus.base_address;
              len    <= bus.frame_len;
              issued <= '0;
              sent   <= '0;
              state  <= READ;
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_go && (issued + ONE == len)) state <= FLUSH;
        end
        FLUSH: begin
          if (pop && (sent == len - ONE)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // inflight is cleared by reset, so a read issued just before an abort is never captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) mem[wr_ptr] <= bus.read_data_out;
  end
endmodule

// File: tb/tb_output_stream_reader.sv
// Directed bench: a frame-level scoreboard (expected word list per frame) checked every cycle,
// plus literal expectations for each scenario.
module tb_output_stream_reader;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  output_stream_reader_if #(.ADD_SIZE(AW), .DATA_SIZE(DW)) bus ();

  output_stream_reader #(.ADD_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rdata = '0;
  assign bus.read_data_out = rdata;
  always @(posedge clk) if (bus.read_en) rdata <= ram[bus.read_address];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame model
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            addr_q[$];
  int  base_m = 0, len_m = 0, reads = 0, beat_idx = 0, start_cyc = 0;
  bit  frame_active = 0, done_flag = 0;
  int  done_cnt = 0, done_cyc = -1, first_vld_cyc = -1, last_beat_cyc = -1;
  int  last_idx = -1, last_cnt = 0;
  bit  prev_stall = 0, prev_last = 0;
  logic [DW-1:0] prev_data = '0;

  // Ready pattern begins 1,0,0,1
  logic [15:0] pat = 16'b1011_0010_1101_1001;
  bit rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    bus.m_ready = rdy_mode ? pat[cyc % 16] : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs_zero",
          {bus.read_en, bus.read_address, bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done}, 0);
    end else begin
      chk("busy", bus.busy, (frame_active && cyc > start_cyc) ? 1 : 0);
      if (bus.read_en) begin
        chk("read_en_allowed", (frame_active && reads < len_m) ? 1 : 0, 1);
        chk("read_address", bus.read_address, (base_m + reads) % DEPTH);
        addr_q.push_back(int'(bus.read_address));
        reads++;
      end
      if (prev_stall) begin
        chk("stall_valid_held", bus.m_valid, 1);
        chk("stall_data_held", bus.m_data, prev_data);
        chk("stall_last_held", bus.m_last, prev_last);
      end
      if (bus.m_valid) begin
        chk("m_valid_in_frame", (frame_active && beat_idx < len_m) ? 1 : 0, 1);
        if (frame_active && beat_idx < len_m) begin
          chk("m_data", bus.m_data, exp_q[beat_idx]);
          chk("m_last", bus.m_last, (beat_idx == len_m - 1) ? 1 : 0);
        end
        if (first_vld_cyc < 0) first_vld_cyc = cyc - start_cyc;
        if (bus.m_ready) begin
          got_q.push_back(bus.m_data);
          if (bus.m_last) begin
            last_idx = beat_idx;
            last_cnt++;
          end
          beat_idx++;
          if (beat_idx == len_m) last_beat_cyc = cyc;
        end
      end
      chk("outstanding_le_2", (reads - beat_idx <= 2) ? 1 : 0, 1);
      if (bus.done) begin
        chk("done_expected", (frame_active && beat_idx == len_m) ? 1 : 0, 1);
        chk("done_cycle", cyc, (len_m == 0) ? start_cyc + 1 : last_beat_cyc + 1);
        done_flag    = 1;
        done_cnt++;
        done_cyc     = cyc - start_cyc;
        frame_active = 0;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic model_clear();
    frame_active = 0;
    reads = 0; beat_idx = 0; len_m = 0;
    prev_stall = 0;
    exp_q.delete();
  endtask

  task automatic do_start(input int b, input int l);
    bus.start = 1'b1;
    bus.base_address = AW'(b);
    bus.frame_len = (AW+1)'(l);
    base_m = b; len_m = l;
    exp_q.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(ram[(b + i) % DEPTH]);
    got_q.delete(); addr_q.delete();
    reads = 0; beat_idx = 0; start_cyc = cyc;
    frame_active = 1; done_flag = 0;
    first_vld_cyc = -1; last_beat_cyc = -1; last_idx = -1; last_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_flag; i++) @(posedge clk);
    chk("done_within_budget", done_flag, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int saved_done;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 3);
    bus.start = 1'b0;
    bus.base_address = '0;
    bus.frame_len = '0;
    bus.m_ready = 1'b1;

    #1 rst = 1'b1;
    #2;
    chk("reset_busy", bus.busy, 0);
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_read_en", bus.read_en, 0);
    chk("reset_done", bus.done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame
    rdy_mode = 0;
    do_start(0, 8);
    wait_done(40);
    chk("basic_beats", got_q.size(), 8);
    chk("basic_first_word", got_q[0], 0);
    chk("basic_last_word", got_q[7], 21);
    chk("basic_first_valid_cycle", first_vld_cyc, 3);
    chk("basic_done_cycle", done_cyc, 11);
    chk("basic_last_count", last_cnt, 1);
    chk("basic_last_index", last_idx, 7);

    // Backpressure
    rdy_mode = 1;
    do_start(100, 16);
    wait_done(300);
    rdy_mode = 0;
    chk("bp_beats", got_q.size(), 16);
    chk("bp_first_word", got_q[0], 300);
    chk("bp_last_word", got_q[15], 345);
    chk("bp_last_index", last_idx, 15);

    // Address wrap
    do_start(2046, 4);
    wait_done(40);
    chk("wrap_addr_count", addr_q.size(), 4);
    chk("wrap_addr0", addr_q[0], 2046);
    chk("wrap_addr1", addr_q[1], 2047);
    chk("wrap_addr2", addr_q[2], 0);
    chk("wrap_addr3", addr_q[3], 1);
    chk("wrap_word1", got_q[1], 6141);
    chk("wrap_word2", got_q[2], 0);

    // Zero length
    do_start(5, 0);
    wait_done(10);
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_reads", addr_q.size(), 0);
    chk("zero_beats", got_q.size(), 0);

    // Full length
    do_start(0, 2048);
    wait_done(2200);
    chk("full_beats", got_q.size(), 2048);
    chk("full_last_index", last_idx, 2047);
    chk("full_last_count", last_cnt, 1);
    chk("full_done_cycle", done_cyc, 2051);
    chk("full_last_word", got_q[2047], 6141);

    // Reset mid-frame after 5 of 10 beats
    do_start(10, 10);
    for (int i = 0; i < 50 && got_q.size() < 5; i++) @(posedge clk);
    chk("midrst_reached_5", got_q.size(), 5);
    saved_done = done_cnt;
    #1 rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_read_en", bus.read_en, 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_m_data", bus.m_data, 0);
    chk("midrst_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", done_cnt, saved_done);
    do_start(100, 3);
    wait_done(40);
    chk("postrst_beats", got_q.size(), 3);
    chk("postrst_word0", got_q[0], 300);
    chk("postrst_word1", got_q[1], 303);
    chk("postrst_word2", got_q[2], 306);

    // Start while busy is ignored
    do_start(200, 6);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_address = AW'(7);
    bus.frame_len = (AW+1)'(2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(40);
    chk("busy_start_beats", got_q.size(), 6);
    chk("busy_start_word5", got_q[5], 615);
    chk("busy_start_done_cycle", done_cyc, 9);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_stays_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
